// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register file dump reader: register file
// geometry and the reader's state encoding.
package regfile_dump_reader_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_COUNT  = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Output word stream of the dump reader.
// Handshake: a word transfers on a rising edge where o_valid and i_ready are
// both high. While o_valid is high and no transfer has happened, o_addr,
// o_data and o_last are held stable. i_ready is ignored while o_valid is low.
interface regfile_dump_reader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              o_valid;
    logic              i_ready;
    logic [ADDR_W-1:0] o_addr;
    logic [DATA_W-1:0] o_data;
    logic              o_last;

    modport master (
        output o_valid, o_addr, o_data, o_last,
        input  i_ready
    );

    modport slave (
        input  o_valid, o_addr, o_data, o_last,
        output i_ready
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// Debug reader that walks an inclusive, wrapping address range of the
// register file through its A read port and streams (address, data) words.
// Each word costs one READ cycle (snapshot) plus at least one PRESENT cycle.
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_W-1:0]     i_first_addr,
    input  logic [ADDR_W-1:0]     i_last_addr,
    input  logic                  i_abort,
    output logic                  o_port_req,
    output logic [ADDR_W-1:0]     o_RA_addr,
    input  logic [DATA_W-1:0]     i_BusA_data,
    regfile_dump_reader_if.master dump,
    output logic                  o_busy,
    output logic                  o_done,
    output state_t                o_state
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] end_addr;
    logic              hs;

    assign hs      = dump.o_valid & dump.i_ready;
    assign o_state = state;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides everything except an IDLE start
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (i_start) state_nxt = ST_READ;
            ST_READ:    state_nxt = i_abort ? ST_IDLE : ST_PRESENT;
            ST_PRESENT: begin
                if (i_abort) begin
                    state_nxt = ST_IDLE;
                end else if (hs) begin
                    state_nxt = dump.o_last ? ST_DONE : ST_READ;
                end
            end
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Output decode; the read port address is parked at 0 when not owned
    always_comb begin
        o_port_req   = (state == ST_READ) || (state == ST_PRESENT);
        dump.o_valid = (state == ST_PRESENT);
        o_busy       = (state != ST_IDLE);
        o_done       = (state == ST_DONE);
        o_RA_addr    = o_port_req ? ptr : '0;
    end

    // Range pointers and the snapshot of the word being presented
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr         <= '0;
            end_addr    <= '0;
            dump.o_addr <= '0;
            dump.o_data <= '0;
            dump.o_last <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        ptr      <= i_first_addr;
                        end_addr <= i_last_addr;
                    end
                end
                ST_READ: begin
                    if (i_abort) begin
                        dump.o_last <= 1'b0;
                    end else begin
                        dump.o_data <= i_BusA_data;
                        dump.o_addr <= ptr;
                        dump.o_last <= (ptr == end_addr);
                    end
                end
                ST_PRESENT: begin
                    if (i_abort) begin
                        dump.o_last <= 1'b0;
                    end else if (hs && !dump.o_last) begin
                        // Natural ADDR_W-bit overflow gives the 31->0 wrap
                        ptr <= ptr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader with a behavioural register
// file and an expected-word queue built from the range rules.
module tb_regfile_dump_reader;
    import regfile_dump_reader_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [4:0]  i_first_addr;
    logic [4:0]  i_last_addr;
    logic        i_abort;
    logic        o_port_req;
    logic [4:0]  o_RA_addr;
    logic [31:0] i_BusA_data;
    logic        o_busy;
    logic        o_done;
    state_t      dbg_state;

    int total = 0;
    int bad   = 0;

    // Expected words: {last, addr, data}
    logic [37:0] exp_q[$];

    // Register file model
    logic [31:0] regs [32];
    logic        load_seq, load_rnd, wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    // Clock
    always #5 i_clk = ~i_clk;

    regfile_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) dump_if();

    regfile_dump_reader dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_first_addr (i_first_addr),
        .i_last_addr  (i_last_addr),
        .i_abort      (i_abort),
        .o_port_req   (o_port_req),
        .o_RA_addr    (o_RA_addr),
        .i_BusA_data  (i_BusA_data),
        .dump         (dump_if.master),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_state      (dbg_state)
    );

    // Register file write port
    always @(posedge i_clk) begin
        if (load_seq) begin
            for (int k = 0; k < 32; k++) regs[k] <= 32'hA000_0000 + k;
        end else if (load_rnd) begin
            for (int k = 0; k < 32; k++) regs[k] <= $urandom;
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign i_BusA_data = regs[o_RA_addr];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    // mode 0: ready always high; 1: random ready; 2: ready low for 7 valid cycles
    task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int mode,
                            input bit wr_read, input string tag);
        int          n, cyc, first_valid, hold_cnt, done_cyc;
        bit          got_done, prev_wait, r;
        logic [37:0] e, held, obs;
        logic [4:0]  a, span;
        span = l - f;
        n = int'(span) + 1;
        exp_q.delete();
        a = f;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == n - 1), a, regs[a]});
            a = a + 5'd1;
        end
        i_first_addr = f;
        i_last_addr  = l;
        i_start      = 1'b1;
        i_ready_set(1'b0);
        tick();
        i_start      = 1'b0;
        i_first_addr = 5'($urandom);
        i_last_addr  = 5'($urandom);
        check({tag, " read port_req"}, o_port_req, 1);
        check({tag, " read valid"}, dump_if.o_valid, 0);
        check({tag, " read ra_addr"}, o_RA_addr, f);
        if (wr_read) begin
            wr_en = 1'b1; wr_addr = f; wr_data = 32'hDEAD_BEEF;
        end
        tick();
        wr_en = 1'b0;
        cyc = 2; first_valid = -1; got_done = 0; prev_wait = 0; hold_cnt = 0; done_cyc = -1;
        held = '0;
        while (!got_done && cyc < 1000) begin
            if (o_done) begin
                got_done = 1;
                done_cyc = cyc;
            end else begin
                case (mode)
                    0:       r = 1'b1;
                    1:       r = 1'($urandom_range(0, 1));
                    default: r = (hold_cnt >= 7);
                endcase
                i_ready_set(r);
                if (dump_if.o_valid) begin
                    obs = {dump_if.o_last, dump_if.o_addr, dump_if.o_data};
                    if (first_valid < 0) first_valid = cyc;
                    if (prev_wait) check({tag, " held stable"}, obs, held);
                    if (r) begin
                        if (exp_q.size() == 0) begin
                            total++; bad++;
                            $error("FAIL %s extra word: observed=%0h expected=none", tag, obs);
                        end else begin
                            e = exp_q.pop_front();
                            check({tag, " word"}, obs, e);
                            check({tag, " present ra_addr"}, o_RA_addr, e[36:32]);
                        end
                        prev_wait = 0;
                    end else begin
                        held = obs;
                        prev_wait = 1;
                        hold_cnt++;
                    end
                end
                tick();
                cyc++;
            end
        end
        check({tag, " done seen"}, got_done, 1);
        check({tag, " queue drained"}, exp_q.size(), 0);
        check({tag, " first valid latency"}, first_valid, 2);
        if (mode == 0) check({tag, " cycles first valid through done"}, done_cyc - first_valid + 1, 2 * n);
        if (mode == 2) check({tag, " wait cycles"}, hold_cnt, 7);
        i_ready_set(1'b0);
        tick();
        check({tag, " done one cycle"}, o_done, 0);
        check({tag, " idle after done"}, o_busy, 0);
    endtask

    task automatic i_ready_set(input logic v);
        dump_if.i_ready = v;
    endtask

    initial begin
        int cnt;
        i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0;
        i_first_addr = '0; i_last_addr = '0;
        dump_if.i_ready = 1'b0;
        load_seq = 1'b0; load_rnd = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        #1;
        check("reset valid", dump_if.o_valid, 0);
        check("reset addr", dump_if.o_addr, 0);
        check("reset data", dump_if.o_data, 0);
        check("reset last", dump_if.o_last, 0);
        check("reset busy", o_busy, 0);
        check("reset done", o_done, 0);
        check("reset port_req", o_port_req, 0);
        check("reset ra_addr", o_RA_addr, 0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        load_seq = 1'b1; tick(); load_seq = 1'b0;

        run_dump(5'd0,  5'd31, 0, 1'b0, "full");
        run_dump(5'd30, 5'd1,  0, 1'b0, "wrap");
        run_dump(5'd5,  5'd5,  2, 1'b0, "hold");
        run_dump(5'd3,  5'd3,  0, 1'b1, "snap");
        check("snap regfile written", regs[3], 32'hDEAD_BEEF);
        run_dump(5'd3,  5'd3,  0, 1'b0, "resnap");
        run_dump(5'd4,  5'd3,  1, 1'b0, "all32");

        // Start and abort together in IDLE: start wins
        i_first_addr = 5'd7; i_last_addr = 5'd7; i_start = 1'b1; i_abort = 1'b1;
        tick();
        i_start = 1'b0; i_abort = 1'b0;
        check("start_vs_abort busy", o_busy, 1);
        check("start_vs_abort port_req", o_port_req, 1);
        tick();
        check("start_vs_abort addr", dump_if.o_addr, 7);
        check("start_vs_abort data", dump_if.o_data, regs[7]);
        dump_if.i_ready = 1'b1;
        tick();
        dump_if.i_ready = 1'b0;
        check("start_vs_abort done", o_done, 1);
        tick();

        // Abort while presenting address 10
        i_first_addr = 5'd0; i_last_addr = 5'd31; i_start = 1'b1; dump_if.i_ready = 1'b1;
        tick();
        i_start = 1'b0;
        cnt = 0;
        while (!(dump_if.o_valid && dump_if.o_addr == 5'd10) && cnt < 200) begin
            tick();
            cnt++;
        end
        check("abort reached addr10", {dump_if.o_valid, dump_if.o_addr}, {1'b1, 5'd10});
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0; dump_if.i_ready = 1'b0;
        check("abort valid", dump_if.o_valid, 0);
        check("abort last", dump_if.o_last, 0);
        check("abort busy", o_busy, 0);
        check("abort port_req", o_port_req, 0);
        check("abort addr kept", dump_if.o_addr, 10);
        check("abort data kept", dump_if.o_data, regs[10]);
        for (int i = 0; i < 3; i++) begin
            check("abort no done", o_done, 0);
            tick();
        end

        // Asynchronous reset mid-dump
        i_start = 1'b1; dump_if.i_ready = 1'b1;
        tick();
        i_start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        i_rst = 1'b1;
        #1;
        check("midreset valid", dump_if.o_valid, 0);
        check("midreset addr", dump_if.o_addr, 0);
        check("midreset data", dump_if.o_data, 0);
        check("midreset busy", o_busy, 0);
        check("midreset done", o_done, 0);
        check("midreset port_req", o_port_req, 0);
        @(negedge i_clk);
        i_rst = 1'b0; dump_if.i_ready = 1'b0;
        tick();
        check("post reset done", o_done, 0);

        // Start while busy is ignored
        i_first_addr = 5'd0; i_last_addr = 5'd31; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        check("busy start first addr", dump_if.o_addr, 0);
        i_start = 1'b1; i_first_addr = 5'd20; i_last_addr = 5'd20;
        tick();
        i_start = 1'b0;
        check("busy start addr held", dump_if.o_addr, 0);
        check("busy start valid held", dump_if.o_valid, 1);
        dump_if.i_ready = 1'b1;
        tick();
        dump_if.i_ready = 1'b0;
        tick();
        check("busy start next word", {dump_if.o_last, dump_if.o_addr, dump_if.o_data},
              {1'b0, 5'd1, regs[1]});
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check("busy start abort idle", o_busy, 0);

        // Random register contents and ranges with random back-pressure
        load_rnd = 1'b1; tick(); load_rnd = 1'b0;
        for (int t = 0; t < 6; t++) begin
            run_dump(5'($urandom), 5'($urandom), 1, 1'b0, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
